// File: rtl/vbfs_apply.sv
// vbfs_apply: vertex-state read / write-back stage of the vBFS pipeline.
// Reads {parent, active} for each incoming message, presents message plus
// state to gather through a single holding stage (S1), and writes gather's
// result back. Clears the state RAM after reset and counts new visits.
// Optional feature: define VBFS_APPLY_FORWARD_EN to forward a same-cycle
// write-back into the read path instead of stalling same-vertex messages.
module vbfs_apply #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                msg_valid,
  output logic                msg_ready,
  input  logic [31:0]         msg_nodeid,
  input  logic [31:0]         msg_sender,
  input  logic [31:0]         msg_level,
  output logic                gather_valid,
  input  logic                gather_ready,
  output logic [31:0]         gather_nodeid,
  output logic [31:0]         gather_sender,
  output logic [31:0]         gather_level,
  output logic [31:0]         gather_parent,
  output logic                gather_active,
  input  logic                result_valid,
  output logic                result_ack,
  input  logic [31:0]         result_nodeid,
  input  logic [31:0]         result_parent,
  input  logic                result_active,
  output logic                init_done,
  output logic [ADDR_WIDTH:0] visited_count
);
  localparam int                  DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] CNT_ONE   = 1;
  localparam logic [ADDR_WIDTH:0]   VC_ONE    = 1;
  localparam logic [ADDR_WIDTH:0]   VC_MAX    = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic [32:0]           mem [DEPTH];

  logic                  s1_valid_q, s1_valid_d;
  logic [31:0]           s1_nodeid_q, s1_sender_q, s1_level_q, s1_parent_q;
  logic                  s1_active_q;
  logic [ADDR_WIDTH:0]   visited_q, visited_d;

  logic                  run, accept, retire, res_acc, wr_en;
  logic [ADDR_WIDTH-1:0] rd_addr, wr_addr, s1_addr;
  logic [32:0]           wr_data, rd_data;
  logic                  unused_upper;

  // State register and sweep counter
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Next state: sweep every address once, then run forever
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == ST_INIT) begin
      init_cnt_d = init_cnt_q + CNT_ONE;
      if (init_cnt_q == LAST_ADDR) state_d = ST_RUN;
    end
  end

  assign run        = (state_q == ST_RUN);
  assign init_done  = run;
  assign result_ack = run;
  assign rd_addr    = msg_nodeid[ADDR_WIDTH-1:0];
  assign s1_addr    = s1_nodeid_q[ADDR_WIDTH-1:0];
  assign res_acc    = result_valid && result_ack;
  assign accept     = msg_valid && msg_ready;
  assign retire     = s1_valid_q && gather_ready;

  // Upper nodeid bits of a write-back never index the RAM.
  assign unused_upper = ^result_nodeid[31:ADDR_WIDTH];

`ifdef VBFS_APPLY_FORWARD_EN
  logic fwd_hit;
  // A write landing this cycle on the address being read wins over the RAM.
  assign fwd_hit   = res_acc && (result_nodeid[ADDR_WIDTH-1:0] == rd_addr);
  assign msg_ready = run && (!s1_valid_q || gather_ready);
  assign rd_data   = fwd_hit ? {result_parent, result_active} : mem[rd_addr];
`else
  // Hold a message for the vertex in S1 until its write-back has landed.
  assign msg_ready = run && (!s1_valid_q || gather_ready)
                     && !(s1_valid_q && (rd_addr == s1_addr));
  assign rd_data   = mem[rd_addr];
`endif

  assign wr_en   = !run || res_acc;
  assign wr_addr = run ? result_nodeid[ADDR_WIDTH-1:0] : init_cnt_q;
  assign wr_data = run ? {result_parent, result_active} : 33'd0;

  // State RAM write port: clear sweep in INIT, write-back in RUN
  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // S1 occupancy: accept wins over a same-cycle retire
  always_comb begin
    s1_valid_d = s1_valid_q;
    if (retire) s1_valid_d = 1'b0;
    if (accept) s1_valid_d = 1'b1;
  end

  // New visit: the entry gather saw was unvisited and now has a parent
  always_comb begin
    visited_d = visited_q;
    if (res_acc && (s1_parent_q == 0) && (result_parent != 0) && (visited_q != VC_MAX))
      visited_d = visited_q + VC_ONE;
  end

  // S1 holding stage and visit counter; read data held while gather stalls
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      s1_valid_q  <= 1'b0;
      s1_nodeid_q <= '0;
      s1_sender_q <= '0;
      s1_level_q  <= '0;
      s1_parent_q <= '0;
      s1_active_q <= 1'b0;
      visited_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      visited_q  <= visited_d;
      if (accept) begin
        s1_nodeid_q <= msg_nodeid;
        s1_sender_q <= msg_sender;
        s1_level_q  <= msg_level;
        s1_parent_q <= rd_data[32:1];
        s1_active_q <= rd_data[0];
      end
    end
  end

  assign gather_valid  = s1_valid_q;
  assign gather_nodeid = s1_nodeid_q;
  assign gather_sender = s1_sender_q;
  assign gather_level  = s1_level_q;
  assign gather_parent = s1_parent_q;
  assign gather_active = s1_active_q;
  assign visited_count = visited_q;

endmodule

// File: tb/tb_vbfs_apply.sv
// Bench for vbfs_apply: directed scenarios plus random traffic against a
// queue/array model of the vertex-state RAM and the S1 stage.
module tb_vbfs_apply;
  localparam int AW = 4;
  localparam int N  = 1 << AW;
`ifdef VBFS_APPLY_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          msg_valid = 1'b0, msg_ready;
  logic [31:0]   msg_nodeid = '0, msg_sender = '0, msg_level = '0;
  logic          gather_valid, gather_ready = 1'b0;
  logic [31:0]   gather_nodeid, gather_sender, gather_level, gather_parent;
  logic          gather_active;
  logic          result_valid = 1'b0, result_ack;
  logic [31:0]   result_nodeid = '0, result_parent = '0;
  logic          result_active = 1'b0;
  logic          init_done;
  logic [AW:0]   visited_count;

  vbfs_apply #(.ADDR_WIDTH(AW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_nodeid(msg_nodeid),
    .msg_sender(msg_sender), .msg_level(msg_level),
    .gather_valid(gather_valid), .gather_ready(gather_ready),
    .gather_nodeid(gather_nodeid), .gather_sender(gather_sender),
    .gather_level(gather_level), .gather_parent(gather_parent),
    .gather_active(gather_active),
    .result_valid(result_valid), .result_ack(result_ack),
    .result_nodeid(result_nodeid), .result_parent(result_parent),
    .result_active(result_active),
    .init_done(init_done), .visited_count(visited_count)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [31:0] nid, snd, lvl, par;
    logic        act;
  } ent_t;

  ent_t        q[$];
  logic [31:0] rparent [N];
  logic        ractive [N];
  int          ref_visited;
  int          total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      rparent[i] = '0;
      ractive[i] = 1'b0;
    end
    q.delete();
    ref_visited = 0;
  endtask

  // One clock cycle, entered and left at posedge+1. The attached gather
  // answers the entry it consumes: unvisited -> parent=sender, active=1,
  // otherwise it writes the stored state back unchanged.
  task automatic cyc(input bit mv, input logic [31:0] nid, input logic [31:0] snd,
                     input logic [31:0] lvl, input bit gr, input bit attach,
                     input int exp_rdy, output bit acc);
    ent_t f, e;
    bit res, ret;
    logic [31:0] np;
    logic na;
    logic [AW-1:0] a, wa;
    msg_valid = mv; msg_nodeid = nid; msg_sender = snd; msg_level = lvl;
    gather_ready = gr;
    res = attach && gr && (q.size() > 0);
    np = $urandom;
    na = 1'($urandom_range(0, 1));
    f = '{default: '0};
    if (res) begin
      f  = q[0];
      np = (f.par == 0) ? f.snd : f.par;
      na = (f.par == 0) ? 1'b1 : f.act;
    end
    result_valid  = res;
    result_nodeid = res ? f.nid : $urandom;
    result_parent = np;
    result_active = na;
    #4;
    chk("gvalid", gather_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("gnode",   gather_nodeid, q[0].nid);
      chk("gsender", gather_sender, q[0].snd);
      chk("glevel",  gather_level,  q[0].lvl);
      chk("gparent", gather_parent, q[0].par);
      chk("gactive", gather_active, q[0].act);
    end
    chk("visited", visited_count, ref_visited);
    if (exp_rdy >= 0) chk("mready", msg_ready, exp_rdy[0]);
    acc = mv && msg_ready;
    ret = gr && (q.size() > 0);
    if (res && f.par == 0 && np != 0 && ref_visited < N) ref_visited++;
    if (acc) begin
      a = nid[AW-1:0];
      e.nid = nid; e.snd = snd; e.lvl = lvl;
      if (res && FWD && f.nid[AW-1:0] == a) begin
        e.par = np; e.act = na;
      end else begin
        e.par = rparent[a]; e.act = ractive[a];
      end
    end
    if (res) begin
      wa = f.nid[AW-1:0];
      rparent[wa] = np;
      ractive[wa] = na;
    end
    if (ret) void'(q.pop_front());
    if (acc) q.push_back(e);
    @(posedge sys_clk); #1;
  endtask

  task automatic send(input logic [31:0] nid, input logic [31:0] snd,
                      input logic [31:0] lvl, input bit attach);
    bit acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) cyc(1'b1, nid, snd, lvl, 1'b1, attach, -1, acc);
    chk("send_accepted", acc, 1'b1);
  endtask

  task automatic idle(input bit gr, input bit attach);
    bit acc;
    cyc(1'b0, $urandom, $urandom, $urandom, gr, attach, -1, acc);
  endtask

  task automatic wait_init();
    int k = 0;
    msg_valid = 1'b0; result_valid = 1'b0; gather_ready = 1'b0;
    while (k < 100) begin
      @(posedge sys_clk); #1;
      k++;
      if (init_done) break;
    end
    chk("init_cycles", k, N);
  endtask

  task automatic read_all();
    logic [31:0] r;
    for (int a = 0; a < N; a++) begin
      r = $urandom;
      send({r[31:AW], a[AW-1:0]}, $urandom, $urandom, 1'b0);
    end
    idle(1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    logic [31:0] r;
    model_reset();
    #1;
    chk("rst_mready",  msg_ready, 1'b0);
    chk("rst_gvalid",  gather_valid, 1'b0);
    chk("rst_rack",    result_ack, 1'b0);
    chk("rst_idone",   init_done, 1'b0);
    chk("rst_gnode",   gather_nodeid, 32'd0);
    chk("rst_gparent", gather_parent, 32'd0);
    chk("rst_gactive", gather_active, 1'b0);
    chk("rst_visited", visited_count, 0);
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    wait_init();
    chk("run_rack", result_ack, 1'b1);
    read_all();

    // single visit then revisit of vertex 5
    send(32'd5, 32'd1, 32'd1, 1'b1);
    idle(1'b1, 1'b1);
    chk("visit1", visited_count, 1);
    send(32'd5, 32'd9, 32'd2, 1'b1);
    chk("revisit_par", gather_parent, 32'd1);
    idle(1'b1, 1'b1);
    chk("visit_same", visited_count, 1);
    send(32'd5, 32'd4, 32'd3, 1'b0);
    chk("ram5_par", gather_parent, 32'd1);
    chk("ram5_act", gather_active, 1'b1);
    idle(1'b1, 1'b0);

    // back-to-back same vertex
    cyc(1'b1, 32'd7, 32'd2, 32'd1, 1'b1, 1'b1, 1, acc);
    cyc(1'b1, 32'd7, 32'd3, 32'd2, 1'b1, 1'b1, FWD ? 1 : 0, acc);
    if (!acc) cyc(1'b1, 32'd7, 32'd3, 32'd2, 1'b1, 1'b1, 1, acc);
    chk("hz_acc", acc, 1'b1);
    chk("hz_par", gather_parent, 32'd2);
    idle(1'b1, 1'b1);

    // backpressure
    send(32'd3, 32'd6, 32'd4, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'd4, 32'd8, 32'd5, 1'b0, 1'b1, 0, acc);
    cyc(1'b1, 32'd4, 32'd8, 32'd5, 1'b1, 1'b1, 1, acc);
    chk("bp_acc", acc, 1'b1);
    idle(1'b1, 1'b1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      cyc($urandom_range(0, 3) != 0,
          {r[31:AW], ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : r[AW-1:0]},
          32'($urandom_range(0, 20)), $urandom,
          $urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, -1, acc);
    end
    repeat (3) idle(1'b1, 1'b1);

    // mid-run reset with S1 occupied
    send(32'd9, 32'd5, 32'd1, 1'b1);
    chk("pre_rst_gvalid", gather_valid, 1'b1);
    sys_rst = 1'b1;
    #1;
    chk("mrst_gvalid",  gather_valid, 1'b0);
    chk("mrst_visited", visited_count, 0);
    chk("mrst_mready",  msg_ready, 1'b0);
    chk("mrst_idone",   init_done, 1'b0);
    chk("mrst_gparent", gather_parent, 32'd0);
    model_reset();
    msg_valid = 1'b0; result_valid = 1'b0;
    @(posedge sys_clk); #1 sys_rst = 1'b0;
    wait_init();
    read_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
